el2_dec_ib_queue: RTL and testbench

Parametrised multi-entry instruction buffer between the IFU aligner and decode. It succeeds the single-slot IB control stage. It decouples fetch from decode with a DEPTH-entry FIFO and a valid/ready handshake. It flushes on pipeline redirect and synthesises debug GPR/CSR access instructions, including the debug-fence indication, while the buffer is empty.

---
 rtl/el2_dec_ib_queue.sv | 178 +++++++++++++++++
 tb/tb_el2_dec_ib_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dec_ib_queue.sv
// Multi-entry instruction buffer between the IFU aligner and decode.
// Also injects debug GPR/CSR access instructions while the buffer is empty.
module el2_dec_ib_queue #(
  parameter int DEPTH     = 4,
  parameter int META_W    = 8,
  parameter int AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       exu_flush_final,
  input  logic                       ifu_i0_valid,
  input  logic [31:0]                ifu_i0_instr,
  input  logic [30:0]                ifu_i0_pc,
  input  logic [META_W-1:0]          ifu_i0_meta,
  output logic                       ifu_ib_ready,
  output logic                       ifu_ib_afull,
  input  logic                       dec_i0_decode_d,
  output logic                       dec_ib0_valid_d,
  output logic [31:0]                dec_i0_instr_d,
  output logic [30:0]                dec_i0_pc_d,
  output logic [META_W-1:0]          dec_i0_meta_d,
  output logic [$clog2(DEPTH+1)-1:0] ib_count,
  input  logic                       dbg_cmd_valid,
  input  logic                       dbg_cmd_write,
  input  logic [1:0]                 dbg_cmd_type,
  input  logic [31:0]                dbg_cmd_addr,
  output logic                       dbg_cmd_ready,
  output logic                       dec_debug_valid_d,
  output logic                       dec_debug_wdata_rs1_d,
  output logic                       dec_debug_fence_d
);

  // state    | meaning
  // DBG_IDLE | no debug instruction held; queue entries drive the head
  // DBG_PEND | synthesised debug instruction presented to decode, fetch blocked

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_PEND = 1'b1
  } dbg_state_t;

  dbg_state_t        dbg_state;
  logic [31:0]       dbg_instr_q;
  logic              dbg_wdata_q;
  logic              dbg_fence_q;

  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic [31:0]       instr_mem [DEPTH];
  logic [30:0]       pc_mem    [DEPTH];
  logic [META_W-1:0] meta_mem  [DEPTH];

  logic              dbg_pend;
  logic              queue_empty;
  logic              push;
  logic              pop;
  logic              dbg_accept;
  logic              dbg_is_csr;
  logic              dbg_addr_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-2 depths work.
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] dbg_encode(input logic        wr,
                                             input logic        csr,
                                             input logic [11:0] a);
    logic [31:0] w;
    if (csr) begin
      w = wr ? {a, 20'h01073} : {a, 20'h02073};
    end else begin
      w = wr ? (32'h0000_6033 | {20'b0, a[4:0], 7'b0})
             : (32'h0000_6033 | {12'b0, a[4:0], 15'b0});
    end
    return w;
  endfunction

  assign dbg_pend        = (dbg_state == DBG_PEND);
  assign queue_empty     = (count_q == '0);
  assign dbg_is_csr      = (dbg_cmd_type == 2'd1);
  assign dbg_addr_unused = ^dbg_cmd_addr[31:12];

  assign ifu_ib_ready    = (count_q < CW'(DEPTH)) & ~dbg_pend;
  assign ifu_ib_afull    = (count_q >= CW'(AFULL_LVL));
  assign dec_ib0_valid_d = ~queue_empty & ~dbg_pend;
  assign ib_count        = count_q;

  assign push = ifu_i0_valid & ifu_ib_ready & ~exu_flush_final;
  assign pop  = dec_i0_decode_d & dec_ib0_valid_d;

  assign dbg_cmd_ready = queue_empty & ~dbg_pend & ~exu_flush_final;
  // Memory-type commands are acknowledged but produce no instruction.
  assign dbg_accept    = dbg_cmd_valid & dbg_cmd_ready & ~dbg_cmd_type[1];

  assign dec_debug_valid_d     = dbg_pend;
  assign dec_debug_wdata_rs1_d = dbg_pend & dbg_wdata_q;
  assign dec_debug_fence_d     = dbg_pend & dbg_fence_q;

  // Entry storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= ifu_i0_instr;
      pc_mem[wr_ptr]    <= ifu_i0_pc;
      meta_mem[wr_ptr]  <= ifu_i0_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (exu_flush_final) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A fetch push landing in the same cycle as a debug accept stays queued
  // behind the debug instruction; the head is masked until it retires.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dbg_state   <= DBG_IDLE;
      dbg_instr_q <= '0;
      dbg_wdata_q <= 1'b0;
      dbg_fence_q <= 1'b0;
    end else begin
      case (dbg_state)
        DBG_IDLE: begin
          if (dbg_accept) begin
            dbg_state   <= DBG_PEND;
            dbg_instr_q <= dbg_encode(dbg_cmd_write, dbg_is_csr, dbg_cmd_addr[11:0]);
            dbg_wdata_q <= dbg_cmd_write;
            dbg_fence_q <= dbg_is_csr & dbg_cmd_write & (dbg_cmd_addr[11:0] == 12'h7C4);
          end
        end
        DBG_PEND: begin
          if (exu_flush_final || dec_i0_decode_d) begin
            dbg_state   <= DBG_IDLE;
            dbg_instr_q <= '0;
            dbg_wdata_q <= 1'b0;
            dbg_fence_q <= 1'b0;
          end
        end
        default: dbg_state <= DBG_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_i0_instr_d = '0;
    dec_i0_pc_d    = '0;
    dec_i0_meta_d  = '0;
    if (dbg_pend) begin
      dec_i0_instr_d = dbg_instr_q;
    end else if (!queue_empty) begin
      dec_i0_instr_d = instr_mem[rd_ptr];
      dec_i0_pc_d    = pc_mem[rd_ptr];
      dec_i0_meta_d  = meta_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_el2_dec_ib_queue.sv
// Directed bench for el2_dec_ib_queue: DEPTH=4 main instance plus a DEPTH=3
// instance sharing the same stimulus for non-power-of-2 wrap.
module tb_el2_dec_ib_queue;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush;
  logic        ifu_valid;
  logic [31:0] ifu_instr;
  logic [30:0] ifu_pc;
  logic [7:0]  ifu_meta;
  logic        decode;
  logic        dbg_valid;
  logic        dbg_write;
  logic [1:0]  dbg_type;
  logic [31:0] dbg_addr;

  logic        ready, afull, ib0_valid, dbg_ready, dbg_vld, dbg_wd, dbg_fence;
  logic [31:0] head_instr;
  logic [30:0] head_pc;
  logic [7:0]  head_meta;
  logic [2:0]  count;

  logic        d3_ready, d3_afull, d3_ib0_valid, d3_dbg_ready, d3_dbg_vld, d3_dbg_wd, d3_dbg_fence;
  logic [31:0] d3_head_instr;
  logic [30:0] d3_head_pc;
  logic [7:0]  d3_head_meta;
  logic [1:0]  d3_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  el2_dec_ib_queue #(.DEPTH(4), .META_W(8), .AFULL_LVL(3)) dut (
    .clk(clk), .rst_l(rst_l), .exu_flush_final(flush),
    .ifu_i0_valid(ifu_valid), .ifu_i0_instr(ifu_instr), .ifu_i0_pc(ifu_pc),
    .ifu_i0_meta(ifu_meta), .ifu_ib_ready(ready), .ifu_ib_afull(afull),
    .dec_i0_decode_d(decode), .dec_ib0_valid_d(ib0_valid),
    .dec_i0_instr_d(head_instr), .dec_i0_pc_d(head_pc), .dec_i0_meta_d(head_meta),
    .ib_count(count), .dbg_cmd_valid(dbg_valid), .dbg_cmd_write(dbg_write),
    .dbg_cmd_type(dbg_type), .dbg_cmd_addr(dbg_addr), .dbg_cmd_ready(dbg_ready),
    .dec_debug_valid_d(dbg_vld), .dec_debug_wdata_rs1_d(dbg_wd),
    .dec_debug_fence_d(dbg_fence)
  );

  el2_dec_ib_queue #(.DEPTH(3), .META_W(8), .AFULL_LVL(2)) dut3 (
    .clk(clk), .rst_l(rst_l), .exu_flush_final(flush),
    .ifu_i0_valid(ifu_valid), .ifu_i0_instr(ifu_instr), .ifu_i0_pc(ifu_pc),
    .ifu_i0_meta(ifu_meta), .ifu_ib_ready(d3_ready), .ifu_ib_afull(d3_afull),
    .dec_i0_decode_d(decode), .dec_ib0_valid_d(d3_ib0_valid),
    .dec_i0_instr_d(d3_head_instr), .dec_i0_pc_d(d3_head_pc), .dec_i0_meta_d(d3_head_meta),
    .ib_count(d3_count), .dbg_cmd_valid(dbg_valid), .dbg_cmd_write(dbg_write),
    .dbg_cmd_type(dbg_type), .dbg_cmd_addr(dbg_addr), .dbg_cmd_ready(d3_dbg_ready),
    .dec_debug_valid_d(d3_dbg_vld), .dec_debug_wdata_rs1_d(d3_dbg_wd),
    .dec_debug_fence_d(d3_dbg_fence)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input int k);
    ifu_valid = v;
    ifu_instr = 32'hA000_0000 + 32'(k);
    ifu_pc    = 31'h100 + 31'(k);
    ifu_meta  = 8'h10 + 8'(k);
  endtask

  initial begin
    rst_l = 1'b0; flush = 1'b0; decode = 1'b0;
    dbg_valid = 1'b0; dbg_write = 1'b0; dbg_type = 2'd0; dbg_addr = '0;
    set_fetch(1'b0, 0);
    #2;
    chk("rst_ready",      32'(ready),      32'd1);
    chk("rst_dbg_ready",  32'(dbg_ready),  32'd1);
    chk("rst_count",      32'(count),      32'd0);
    chk("rst_ib0_valid",  32'(ib0_valid),  32'd0);
    chk("rst_instr",      head_instr,      32'd0);
    chk("rst_afull",      32'(afull),      32'd0);
    chk("rst_dbg_valid",  32'(dbg_vld),    32'd0);
    rst_l = 1'b1;

    // Fill with decode stalled: 5 offered, 4 accepted.
    for (int k = 0; k < 5; k++) begin
      set_fetch(1'b1, k);
      step();
      chk("fill_count", 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
      chk("fill_afull", 32'(afull), (k >= 2) ? 32'd1 : 32'd0);
      chk("fill_head",  head_instr, 32'hA000_0000);
    end
    chk("full_ready", 32'(ready), 32'd0);
    chk("d3_full_count", 32'(d3_count), 32'd3);
    set_fetch(1'b0, 0);
    decode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_instr", head_instr, 32'hA000_0000 + 32'(k));
      chk("drain_pc",    32'(head_pc),   32'h100 + 32'(k));
      chk("drain_meta",  32'(head_meta), 32'h10 + 32'(k));
      step();
    end
    decode = 1'b0;
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_valid", 32'(ib0_valid), 32'd0);
    chk("drain_instr0", head_instr,    32'd0);
    chk("drain_ready", 32'(ready),     32'd1);

    // Concurrent push/pop at occupancy 2, pointers wrap several times.
    for (int k = 0; k < 2; k++) begin
      set_fetch(1'b1, 16 + k);
      step();
    end
    chk("pp_start_count", 32'(count), 32'd2);
    decode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_fetch(1'b1, 18 + k);
      chk("pp_head",    head_instr,    32'hA000_0010 + 32'(k));
      chk("d3_pp_head", d3_head_instr, 32'hA000_0010 + 32'(k));
      step();
      chk("pp_count",    32'(count),    32'd2);
      chk("d3_pp_count", 32'(d3_count), 32'd2);
    end
    set_fetch(1'b0, 0);
    chk("pp_tail0", head_instr, 32'hA000_001A);
    step();
    chk("pp_tail1", head_instr, 32'hA000_001B);
    chk("d3_pp_tail1", d3_head_instr, 32'hA000_001B);
    step();
    decode = 1'b0;
    chk("pp_end_count",    32'(count),    32'd0);
    chk("d3_pp_end_count", 32'(d3_count), 32'd0);

    // Flush at occupancy 3 with a coincident push.
    for (int k = 0; k < 3; k++) begin
      set_fetch(1'b1, 32 + k);
      step();
    end
    chk("fl_pre_count", 32'(count), 32'd3);
    set_fetch(1'b1, 35);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_fetch(1'b0, 0);
    chk("fl_count", 32'(count),     32'd0);
    chk("fl_valid", 32'(ib0_valid), 32'd0);
    chk("fl_instr", head_instr,     32'd0);
    chk("d3_fl_count", 32'(d3_count), 32'd0);
    set_fetch(1'b1, 48);
    step();
    set_fetch(1'b0, 0);
    chk("fl_next_head", head_instr, 32'hA000_0030);
    chk("fl_next_count", 32'(count), 32'd1);
    decode = 1'b1;
    step();
    decode = 1'b0;

    // Debug GPR write x5 on empty queue.
    dbg_valid = 1'b1; dbg_write = 1'b1; dbg_type = 2'd0; dbg_addr = 32'd5;
    chk("gpr_cmd_ready", 32'(dbg_ready), 32'd1);
    step();
    dbg_valid = 1'b0;
    chk("gpr_instr",   head_instr,       32'h0000_62B3);
    chk("gpr_dvalid",  32'(dbg_vld),     32'd1);
    chk("gpr_wdata",   32'(dbg_wd),      32'd1);
    chk("gpr_fence",   32'(dbg_fence),   32'd0);
    chk("gpr_ib0",     32'(ib0_valid),   32'd0);
    chk("gpr_ready",   32'(ready),       32'd0);
    chk("gpr_pc",      32'(head_pc),     32'd0);
    chk("gpr_cmdrdy",  32'(dbg_ready),   32'd0);
    set_fetch(1'b1, 64);
    step();
    set_fetch(1'b0, 0);
    chk("gpr_blocked_count", 32'(count), 32'd0);
    chk("gpr_still_pend", 32'(dbg_vld), 32'd1);
    decode = 1'b1;
    step();
    decode = 1'b0;
    chk("gpr_done_dvalid", 32'(dbg_vld), 32'd0);
    chk("gpr_done_ready",  32'(ready),   32'd1);

    // Same command with one entry queued: refused.
    set_fetch(1'b1, 80);
    step();
    set_fetch(1'b0, 0);
    dbg_valid = 1'b1;
    chk("gpr_busy_cmdrdy", 32'(dbg_ready), 32'd0);
    step();
    dbg_valid = 1'b0;
    chk("gpr_busy_dvalid", 32'(dbg_vld), 32'd0);
    chk("gpr_busy_head",   head_instr,   32'hA000_0050);
    decode = 1'b1;
    step();
    decode = 1'b0;

    // CSR write to dcsr-fence address.
    dbg_valid = 1'b1; dbg_write = 1'b1; dbg_type = 2'd1; dbg_addr = 32'h7C4;
    step();
    dbg_valid = 1'b0;
    chk("csrw_instr", head_instr,     32'h7C40_1073);
    chk("csrw_fence", 32'(dbg_fence), 32'd1);
    chk("csrw_wdata", 32'(dbg_wd),    32'd1);
    decode = 1'b1;
    step();
    decode = 1'b0;

    // CSR read of 0x300.
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_type = 2'd1; dbg_addr = 32'h300;
    step();
    dbg_valid = 1'b0;
    chk("csrr_instr", head_instr,     32'h3000_2073);
    chk("csrr_fence", 32'(dbg_fence), 32'd0);
    chk("csrr_wdata", 32'(dbg_wd),    32'd0);
    chk("csrr_dvalid", 32'(dbg_vld),  32'd1);
    decode = 1'b1;
    step();
    decode = 1'b0;

    // Memory-type command: acknowledged, nothing synthesised.
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_type = 2'd2; dbg_addr = 32'h1000;
    chk("mem_cmdrdy", 32'(dbg_ready), 32'd1);
    step();
    dbg_valid = 1'b0;
    chk("mem_dvalid", 32'(dbg_vld), 32'd0);
    chk("mem_ready",  32'(ready),   32'd1);
    chk("mem_instr",  head_instr,   32'd0);

    // Asynchronous reset at occupancy 2.
    for (int k = 0; k < 2; k++) begin
      set_fetch(1'b1, 96 + k);
      step();
    end
    set_fetch(1'b0, 0);
    chk("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst_l = 1'b0;
    #1;
    chk("ar_count",   32'(count),     32'd0);
    chk("ar_ready",   32'(ready),     32'd1);
    chk("ar_cmdrdy",  32'(dbg_ready), 32'd1);
    chk("ar_ib0",     32'(ib0_valid), 32'd0);
    chk("ar_instr",   head_instr,     32'd0);
    chk("ar_pc",      32'(head_pc),   32'd0);
    chk("ar_meta",    32'(head_meta), 32'd0);
    chk("ar_afull",   32'(afull),     32'd0);
    chk("d3_ar_count", 32'(d3_count), 32'd0);
    rst_l = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
